// File: rtl/outport_arbiter_if.sv
// Handshake bundle between one output-port arbiter and its surroundings.
// Signal names carry the direction as seen from the arbiter.
//   req_i           per-input head-of-line request [0]=N [1]=S [2]=E [3]=W [4]=L
//   tail_i          head flit of input k is a packet tail
//   credit_i        1-cycle pulse, downstream freed one slot
//   grant_o         one-hot pop strobe to the winning input buffer
//   address_route_o output mux select, 3'b111 when no owner
//   valid_o         flit on mux output is valid this cycle
//   credit_cnt_o    free downstream slots
//   err_o           sticky credit-overflow flag
// Modport slave is taken by the arbiter; master by whoever drives it.
interface outport_arbiter_if #(
  parameter int CREDITS = 4
);
  localparam int CW = $clog2(CREDITS + 1);

  logic [4:0]    req_i;
  logic [4:0]    tail_i;
  logic          credit_i;
  logic [4:0]    grant_o;
  logic [2:0]    address_route_o;
  logic          valid_o;
  logic [CW-1:0] credit_cnt_o;
  logic          err_o;

  modport slave (
    input  req_i, tail_i, credit_i,
    output grant_o, address_route_o, valid_o, credit_cnt_o, err_o
  );

  modport master (
    output req_i, tail_i, credit_i,
    input  grant_o, address_route_o, valid_o, credit_cnt_o, err_o
  );
endinterface

// File: rtl/outport_arbiter.sv
// Per-output-port switch allocator of a 5-port mesh router.
// Round-robin arbitrates the head-of-line requests aimed at this output,
// locks the winner from head to tail flit, drives the output mux select and
// tracks downstream credits so no flit leaves without a free slot.
// Ports:
//   clk_i    router clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   bus      outport_arbiter_if.slave (request/tail/credit in,
//            grant/route/valid/credit count/error out)
module outport_arbiter #(
  parameter int CREDITS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  outport_arbiter_if.slave     bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CREDITS);
  localparam logic [2:0] NONE = 3'b111;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q;
  logic [2:0]    owner_q;   // doubles as the registered route select
  logic [2:0]    rr_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          err_q;
  logic          err_set;

  logic [4:0]    owner_oh;
  logic          xfer;
  logic          tail_hit;
  logic [2:0]    winner;

  // First requester found when scanning ptr, ptr+1, ... modulo 5.
  // The loop runs from the farthest offset down so the nearest one wins.
  function automatic logic [2:0] rr_pick(input logic [4:0] req,
                                         input logic [2:0] ptr);
    logic [3:0] s;
    logic [2:0] pick;
    pick = NONE;
    for (int i = 4; i >= 0; i--) begin
      s = {1'b0, ptr} + 4'(i);
      if (s >= 4'd5) s = s - 4'd5;
      if (req[s[2:0]]) pick = s[2:0];
    end
    return pick;
  endfunction

  assign winner   = rr_pick(bus.req_i, rr_ptr_q);
  assign owner_oh = (state_q == BUSY) ? (5'b00001 << owner_q) : 5'b00000;
  assign xfer     = (|(owner_oh & bus.req_i)) && (cnt_q != '0);
  assign tail_hit = |(owner_oh & bus.tail_i);

  // Credit bookkeeping; a simultaneous send and return cancel out.
  always_comb begin
    cnt_d   = cnt_q;
    err_set = 1'b0;
    if (xfer && !bus.credit_i) begin
      cnt_d = cnt_q - CW'(1);
    end else if (bus.credit_i && !xfer) begin
      if (cnt_q == CNT_MAX) err_set = 1'b1;
      else                  cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      owner_q  <= NONE;
      rr_ptr_q <= 3'd0;
      cnt_q    <= CNT_MAX;
      err_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (err_set) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if ((|bus.req_i) && (cnt_q != '0)) begin
            owner_q <= winner;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (xfer && tail_hit) begin
            state_q  <= IDLE;
            owner_q  <= NONE;
            rr_ptr_q <= (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          owner_q <= NONE;
        end
      endcase
    end
  end

  assign bus.grant_o         = xfer ? owner_oh : 5'b00000;
  assign bus.valid_o         = xfer;
  assign bus.address_route_o = owner_q;
  assign bus.credit_cnt_o    = cnt_q;
  assign bus.err_o           = err_q;
endmodule

// File: tb/tb_outport_arbiter.sv
// Directed bench for outport_arbiter with hand-computed expectations.
module tb_outport_arbiter;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  outport_arbiter_if #(.CREDITS(4)) bus ();

  outport_arbiter #(.CREDITS(4)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] route,
                           input logic [4:0] grant, input logic valid,
                           input logic [2:0] cnt);
    check({tag, ".route"}, 32'(bus.address_route_o), 32'(route));
    check({tag, ".grant"}, 32'(bus.grant_o), 32'(grant));
    check({tag, ".valid"}, 32'(bus.valid_o), 32'(valid));
    check({tag, ".cnt"},   32'(bus.credit_cnt_o), 32'(cnt));
  endtask

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic cyc(input logic [4:0] r, input logic [4:0] t, input logic c);
    @(posedge clk);
    #1;
    bus.req_i    = r;
    bus.tail_i   = t;
    bus.credit_i = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req_i    = 5'b0;
    bus.tail_i   = 5'b0;
    bus.credit_i = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    bus.req_i    = 5'b0;
    bus.tail_i   = 5'b0;
    bus.credit_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst", 3'b111, 5'b0, 1'b0, 3'd4);
    check("rst.err", 32'(bus.err_o), 32'd0);
    do_reset();

    // 1: single-flit packet from N
    cyc(5'b00001, 5'b00001, 1'b0);
    check_out("t1.c1", 3'b111, 5'b0, 1'b0, 3'd4);
    cyc(5'b00001, 5'b00001, 1'b0);
    check_out("t1.c2", 3'b000, 5'b00001, 1'b1, 3'd4);
    cyc(5'b00000, 5'b00000, 1'b0);
    check_out("t1.c3", 3'b111, 5'b0, 1'b0, 3'd3);

    // 2: all request single-flit packets, credit returned on each transfer
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc(5'b11111, 5'b11111, 1'b0);
      check_out($sformatf("t2.idle%0d", k), 3'b111, 5'b0, 1'b0, 3'd4);
      cyc(5'b11111, 5'b11111, 1'b1);
      check_out($sformatf("t2.busy%0d", k), 3'(k % 5),
                5'(1 << (k % 5)), 1'b1, 3'd4);
    end

    // 3: W 3-flit packet while N keeps requesting (rr_ptr is S now)
    cyc(5'b01001, 5'b00000, 1'b0);
    check_out("t3.idle", 3'b111, 5'b0, 1'b0, 3'd4);
    for (int f = 0; f < 3; f++) begin
      cyc(5'b01001, (f == 2) ? 5'b01000 : 5'b00000, 1'b1);
      check_out($sformatf("t3.w%0d", f), 3'b011, 5'b01000, 1'b1, 3'd4);
    end
    cyc(5'b10001, 5'b10001, 1'b0);
    check_out("t3.idle2", 3'b111, 5'b0, 1'b0, 3'd4);
    cyc(5'b10001, 5'b10001, 1'b1);
    check_out("t3.l", 3'b100, 5'b10000, 1'b1, 3'd4);
    cyc(5'b00001, 5'b00001, 1'b0);
    cyc(5'b00001, 5'b00001, 1'b1);
    check_out("t3.n", 3'b000, 5'b00001, 1'b1, 3'd4);

    // 4: L 6-flit packet with credit starvation
    cyc(5'b10000, 5'b00000, 1'b0);
    for (int f = 0; f < 4; f++) begin
      cyc(5'b10000, 5'b00000, 1'b0);
      check_out($sformatf("t4.f%0d", f), 3'b100, 5'b10000, 1'b1, 3'(4 - f));
    end
    cyc(5'b10000, 5'b00000, 1'b0);
    check_out("t4.stall", 3'b100, 5'b0, 1'b0, 3'd0);
    cyc(5'b10000, 5'b00000, 1'b1);
    check_out("t4.stallc", 3'b100, 5'b0, 1'b0, 3'd0);
    cyc(5'b10000, 5'b00000, 1'b0);
    check_out("t4.f4", 3'b100, 5'b10000, 1'b1, 3'd1);
    cyc(5'b10000, 5'b00000, 1'b1);
    check_out("t4.stall2", 3'b100, 5'b0, 1'b0, 3'd0);
    cyc(5'b10000, 5'b10000, 1'b0);
    check_out("t4.f5", 3'b100, 5'b10000, 1'b1, 3'd1);
    cyc(5'b00001, 5'b00001, 1'b0);
    check_out("t4.nocred0", 3'b111, 5'b0, 1'b0, 3'd0);
    cyc(5'b00001, 5'b00001, 1'b0);
    check_out("t4.nocred1", 3'b111, 5'b0, 1'b0, 3'd0);
    for (int c = 0; c < 4; c++) cyc(5'b0, 5'b0, 1'b1);
    cyc(5'b0, 5'b0, 1'b0);
    check_out("t4.refill", 3'b111, 5'b0, 1'b0, 3'd4);
    check("t4.err", 32'(bus.err_o), 32'd0);

    // 5: send and credit in the same cycle, then credit overflow
    cyc(5'b00001, 5'b00000, 1'b0);
    cyc(5'b00001, 5'b00000, 1'b0);
    cyc(5'b00001, 5'b00000, 1'b0);
    cyc(5'b00001, 5'b00001, 1'b1);
    check_out("t5.both", 3'b000, 5'b00001, 1'b1, 3'd2);
    cyc(5'b0, 5'b0, 1'b0);
    check("t5.cnt2", 32'(bus.credit_cnt_o), 32'd2);
    cyc(5'b0, 5'b0, 1'b1);
    cyc(5'b0, 5'b0, 1'b1);
    cyc(5'b0, 5'b0, 1'b1);
    check("t5.err_pre", 32'(bus.err_o), 32'd0);
    cyc(5'b0, 5'b0, 1'b0);
    check("t5.cnt4", 32'(bus.credit_cnt_o), 32'd4);
    check("t5.err", 32'(bus.err_o), 32'd1);
    cyc(5'b0, 5'b0, 1'b0);
    check("t5.err_sticky", 32'(bus.err_o), 32'd1);

    // 6: reset in the middle of an S packet
    cyc(5'b00010, 5'b00000, 1'b0);
    for (int f = 0; f < 3; f++) begin
      cyc(5'b00010, 5'b00000, 1'b0);
      check_out($sformatf("t6.s%0d", f), 3'b001, 5'b00010, 1'b1, 3'(4 - f));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_out("t6.rst", 3'b111, 5'b0, 1'b0, 3'd4);
    check("t6.err", 32'(bus.err_o), 32'd0);
    #2;
    bus.req_i  = 5'b00011;
    bus.tail_i = 5'b00011;
    rst_n      = 1'b1;
    cyc(5'b00011, 5'b00011, 1'b0);
    check_out("t6.n", 3'b000, 5'b00001, 1'b1, 3'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
